// File: rtl/fetch_sequencer.sv
// Front-end PC sequencer: owns the PC, issues one instruction-memory request
// at a time, buffers the returned instruction for decode and applies
// JALR / JAL / branch redirects when decode consumes the buffered instruction.
module fetch_sequencer #(
    parameter int                      CORE         = 0,
    parameter int                      DATA_WIDTH   = 32,
    parameter int                      ADDRESS_BITS = 20,
    parameter logic [ADDRESS_BITS-1:0] RESET_PC     = '0
) (
    input  logic                    clock,
    input  logic                    reset,
    output logic                    imem_req,
    output logic [ADDRESS_BITS-1:0] imem_addr,
    input  logic                    imem_gnt,
    input  logic                    imem_rvalid,
    input  logic [DATA_WIDTH-1:0]   imem_rdata,
    output logic                    inst_valid,
    input  logic                    inst_ready,
    output logic [DATA_WIDTH-1:0]   instruction,
    output logic [ADDRESS_BITS-1:0] inst_PC,
    input  logic                    branch,
    input  logic [ADDRESS_BITS-1:0] branch_target,
    input  logic                    JAL,
    input  logic [ADDRESS_BITS-1:0] JAL_target,
    input  logic                    JALR,
    input  logic [ADDRESS_BITS-1:0] JALR_target,
    output logic                    misaligned
);

    // CORE only tags the instance; reject nonsense values at elaboration.
    if (CORE < 0) begin : g_bad_core
        $error("fetch_sequencer: CORE must be non-negative");
    end

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_DRAIN = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic [ADDRESS_BITS-1:0] r_pc;
    logic                    r_inst_valid;
    logic [DATA_WIDTH-1:0]   r_instruction;
    logic [ADDRESS_BITS-1:0] r_inst_pc;
    logic                    r_misaligned;

    logic                    w_req;
    logic                    w_granted;
    logic                    w_consume;
    logic                    w_redirect;
    logic [ADDRESS_BITS-1:0] w_target;
    logic                    w_target_mis;
    logic                    w_refill;
    logic [ADDRESS_BITS-1:0] w_pc_plus4;

    // A redirect only exists when decode actually takes the buffered instruction.
    assign w_consume  = r_inst_valid & inst_ready;
    assign w_redirect = w_consume & (JALR | JAL | branch);

    // Priority JALR > JAL > branch.
    assign w_target = JALR ? JALR_target :
                      JAL  ? JAL_target  : branch_target;

    assign w_target_mis = w_redirect & (|w_target[1:0]);
    assign w_granted    = w_req & imem_gnt;

    // A response that coincides with a redirect belongs to the old path and is dropped.
    assign w_refill   = (r_state == S_WAIT) & imem_rvalid & ~w_redirect;
    assign w_pc_plus4 = r_pc + ADDRESS_BITS'(4);

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; a misaligned redirect lands in HALT, via DRAIN when a response is still owed.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                w_next_state = S_FETCH;
            end
            S_FETCH: begin
                if (w_redirect) begin
                    if (w_granted) begin
                        w_next_state = S_DRAIN;
                    end else if (w_target_mis) begin
                        w_next_state = S_HALT;
                    end else begin
                        w_next_state = S_FETCH;
                    end
                end else if (w_granted) begin
                    w_next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_redirect) begin
                    if (imem_rvalid) begin
                        w_next_state = w_target_mis ? S_HALT : S_FETCH;
                    end else begin
                        w_next_state = S_DRAIN;
                    end
                end else if (imem_rvalid) begin
                    w_next_state = S_FETCH;
                end
            end
            S_DRAIN: begin
                // misaligned is sticky, so it also records that the drain ends in HALT.
                if (imem_rvalid) begin
                    w_next_state = r_misaligned ? S_HALT : S_FETCH;
                end
            end
            S_HALT: begin
                w_next_state = S_HALT;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Request is raised in FETCH once the buffer is free (empty or being consumed).
    always_comb begin
        w_req = 1'b0;
        if (r_state == S_FETCH) begin
            w_req = ~r_inst_valid | inst_ready;
        end
    end

    // PC, instruction buffer and sticky misalignment flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pc          <= RESET_PC;
            r_inst_valid  <= 1'b0;
            r_instruction <= '0;
            r_inst_pc     <= '0;
            r_misaligned  <= 1'b0;
        end else begin
            if (w_redirect) begin
                r_pc         <= w_target;
                r_inst_valid <= 1'b0;
                if (w_target_mis) begin
                    r_misaligned <= 1'b1;
                end
            end else if (w_refill) begin
                // Refill wins over a plain consume so delivery can be back-to-back.
                r_pc          <= w_pc_plus4;
                r_inst_valid  <= 1'b1;
                r_instruction <= imem_rdata;
                r_inst_pc     <= r_pc;
            end else if (w_consume) begin
                r_inst_valid <= 1'b0;
            end
        end
    end

    assign imem_req    = w_req;
    assign imem_addr   = r_pc;
    assign inst_valid  = r_inst_valid;
    assign instruction = r_instruction;
    assign inst_PC     = r_inst_pc;
    assign misaligned  = r_misaligned;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer (ADDRESS_BITS = 20, DATA_WIDTH = 32).
module tb_fetch_sequencer;

  localparam int DW = 32;
  localparam int AB = 20;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          imem_req;
  logic [AB-1:0] imem_addr;
  logic          imem_gnt = 1'b0;
  logic          imem_rvalid = 1'b0;
  logic [DW-1:0] imem_rdata = '0;
  logic          inst_valid;
  logic          inst_ready = 1'b0;
  logic [DW-1:0] instruction;
  logic [AB-1:0] inst_PC;
  logic          branch = 1'b0;
  logic [AB-1:0] branch_target = '0;
  logic          JAL = 1'b0;
  logic [AB-1:0] JAL_target = '0;
  logic          JALR = 1'b0;
  logic [AB-1:0] JALR_target = '0;
  logic          misaligned;

  int n_cmp = 0;
  int n_err = 0;
  bit done = 1'b0;

  always #5 clock = ~clock;

  fetch_sequencer #(
    .CORE(0), .DATA_WIDTH(DW), .ADDRESS_BITS(AB), .RESET_PC('0)
  ) dut (
    .clock(clock), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .instruction(instruction), .inst_PC(inst_PC),
    .branch(branch), .branch_target(branch_target),
    .JAL(JAL), .JAL_target(JAL_target),
    .JALR(JALR), .JALR_target(JALR_target),
    .misaligned(misaligned)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    #100000;
    if (!done) begin
      n_err++;
      $error("FAIL timeout: bench did not complete");
      $finish;
    end
  end

  initial begin
    // T1: reset values and first request
    repeat (3) tick();
    chk("rst_req", imem_req, 1'b0);
    chk("rst_valid", inst_valid, 1'b0);
    chk("rst_instr", instruction, 32'h0);
    chk("rst_instpc", inst_PC, 20'h0);
    chk("rst_mis", misaligned, 1'b0);
    chk("rst_addr", imem_addr, 20'h0);
    reset = 1'b1;
    settle();
    chk("idle_req", imem_req, 1'b0);
    tick();
    chk("t1_req", imem_req, 1'b1);
    chk("t1_addr", imem_addr, 20'h00000);
    chk("t1_valid", inst_valid, 1'b0);

    // T2: sequential fetch, gnt/rvalid held high
    imem_gnt = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h00000013; inst_ready = 1'b1;
    settle();
    tick();
    chk("t2_wait_valid", inst_valid, 1'b0);
    chk("t2_wait_req", imem_req, 1'b0);
    tick();
    chk("t2_valid0", inst_valid, 1'b1);
    chk("t2_pc0", inst_PC, 20'h00000);
    chk("t2_instr0", instruction, 32'h00000013);
    chk("t2_addr4", imem_addr, 20'h00004);
    tick(); tick();
    chk("t2_pc4", inst_PC, 20'h00004);
    tick(); tick();
    chk("t2_pc8", inst_PC, 20'h00008);
    chk("t2_addrC", imem_addr, 20'h0000C);

    // T3: backpressure for 5 cycles
    inst_ready = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'hDEADBEEF;
    settle();
    chk("t3_req_off", imem_req, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_req", imem_req, 1'b0);
      chk("t3_valid", inst_valid, 1'b1);
      chk("t3_pc", inst_PC, 20'h00008);
      chk("t3_instr", instruction, 32'h00000013);
    end
    inst_ready = 1'b1; imem_gnt = 1'b1; imem_rdata = 32'h00100093;
    settle();
    chk("t3_resume_req", imem_req, 1'b1);
    chk("t3_resume_addr", imem_addr, 20'h0000C);
    tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1;
    settle();
    tick();
    chk("t3_pcC", inst_PC, 20'h0000C);
    chk("t3_instr2", instruction, 32'h00100093);
    chk("t3_valid2", inst_valid, 1'b1);
    chk("t3_addr10", imem_addr, 20'h00010);
    imem_rvalid = 1'b0;

    // T4: JALR redirect while the next request is outstanding; stale response dropped
    JALR = 1'b1; JALR_target = 20'h00100; imem_gnt = 1'b1;
    settle();
    tick();
    JALR = 1'b0; imem_gnt = 1'b0;
    settle();
    chk("t4_valid_clr", inst_valid, 1'b0);
    chk("t4_drain_req", imem_req, 1'b0);
    tick();
    chk("t4_drain_req2", imem_req, 1'b0);
    imem_rvalid = 1'b1; imem_rdata = 32'hBAD0BAD0;
    settle();
    tick();
    imem_rvalid = 1'b0;
    settle();
    chk("t4_stale_valid", inst_valid, 1'b0);
    chk("t4_stale_instr", instruction, 32'h00100093);
    chk("t4_req", imem_req, 1'b1);
    chk("t4_addr", imem_addr, 20'h00100);
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h00000013;
    settle();
    tick();
    imem_rvalid = 1'b0;
    chk("t4_pc", inst_PC, 20'h00100);
    chk("t4_valid", inst_valid, 1'b1);

    // T5: JAL beats branch on the same consume, request not granted
    JAL = 1'b1; JAL_target = 20'h00200; branch = 1'b1; branch_target = 20'h00300;
    settle();
    tick();
    JAL = 1'b0; branch = 1'b0;
    settle();
    chk("t5_req", imem_req, 1'b1);
    chk("t5_addr", imem_addr, 20'h00200);
    chk("t5_valid", inst_valid, 1'b0);
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1;
    settle();
    tick();
    imem_rvalid = 1'b0;
    chk("t5_pc", inst_PC, 20'h00200);

    // PC wrap at the top of the 20-bit space
    JAL = 1'b1; JAL_target = 20'hFFFFC;
    settle();
    tick();
    JAL = 1'b0;
    settle();
    chk("wrap_addr_top", imem_addr, 20'hFFFFC);
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1;
    settle();
    tick();
    imem_rvalid = 1'b0;
    chk("wrap_pc", inst_PC, 20'hFFFFC);
    chk("wrap_addr0", imem_addr, 20'h00000);

    // JALR beats JAL
    JALR = 1'b1; JALR_target = 20'h00400; JAL = 1'b1; JAL_target = 20'h00500;
    settle();
    tick();
    JALR = 1'b0; JAL = 1'b0;
    settle();
    chk("prio_jalr_addr", imem_addr, 20'h00400);
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1;
    settle();
    tick();
    imem_rvalid = 1'b0;
    chk("prio_pc", inst_PC, 20'h00400);

    // T6: misaligned branch target halts until reset
    branch = 1'b1; branch_target = 20'h00102;
    settle();
    tick();
    branch = 1'b0;
    settle();
    chk("t6_mis", misaligned, 1'b1);
    chk("t6_valid", inst_valid, 1'b0);
    chk("t6_req", imem_req, 1'b0);
    imem_gnt = 1'b1; imem_rvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t6_halt_req", imem_req, 1'b0);
      chk("t6_halt_mis", misaligned, 1'b1);
    end
    reset = 1'b0;
    settle();
    chk("t6_rst_mis", misaligned, 1'b0);
    chk("t6_rst_req", imem_req, 1'b0);
    tick();
    reset = 1'b1;
    settle();
    tick();
    chk("t6_post_req", imem_req, 1'b1);
    chk("t6_post_addr", imem_addr, 20'h00000);
    chk("t6_post_valid", inst_valid, 1'b0);
    imem_gnt = 1'b0; imem_rvalid = 1'b0;

    done = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
